// File: rtl/maxpool2x2_ctrl_pkg.sv
// rtl/maxpool2x2_ctrl_pkg.sv - shared types and constants for the 2x2 max-pool controller.
package maxpool_pkg;
  localparam int DATA_W   = 18;
  localparam int SIGN_BIT = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [DATA_W-1:0] sample_t;
endpackage

// File: rtl/maxpool2x2_ctrl_if.sv
// rtl/maxpool2x2_ctrl_if.sv - input and output valid/ready streams of the max-pool controller.
interface maxpool2x2_ctrl_if #(
  parameter int DATA_W = maxpool_pkg::DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/maxpool2x2_ctrl_sm_max2.sv
// rtl/maxpool2x2_ctrl_sm_max2.sv - combinational sign-magnitude max of two samples.
module sm_max2 #(
  parameter int DATA_W = maxpool_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  logic              sa, sb;
  logic [DATA_W-2:0] ma, mb;

  assign sa = a[DATA_W-1];
  assign sb = b[DATA_W-1];
  assign ma = a[DATA_W-2:0];
  assign mb = b[DATA_W-2:0];

  always_comb begin
    y = b;
    // Differing signs also settles +0 against -0.
    if (sa != sb)    y = sa ? b : a;
    else if (!sa)    y = (ma > mb) ? a : b;
    else             y = (mb < ma) ? b : a;
  end
endmodule

// File: rtl/maxpool2x2_ctrl.sv
// rtl/maxpool2x2_ctrl.sv - 2x2/stride-2 sign-magnitude max-pool stream controller.
// Optional fused ReLU on the pooled output: define MAXPOOL_RELU_EN.
module maxpool2x2_ctrl
  import maxpool_pkg::*;
#(
  parameter int DATA_W = maxpool_pkg::DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  maxpool2x2_ctrl_if.slave bus,
  output logic             busy,
  output logic             done
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int HALF  = IMG_W / 2;
  localparam int LB_AW = (HALF > 1) ? $clog2(HALF) : 1;

  state_t             state, state_nx;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [LB_AW-1:0]   lb_idx;
  logic [1:0]         phase;
  logic [DATA_W-1:0]  hold, out_q, cmp_a, cmp_y, pooled;
  logic [DATA_W-1:0]  lbuf [HALF];
  logic               out_valid_q, in_hs, out_hs, col_last, row_last;

  assign phase    = {row[0], col[0]};
  assign lb_idx   = LB_AW'(col >> 1);
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));

  assign bus.in_ready  = (state == RUN) && !(out_valid_q && !bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = out_valid_q && bus.out_ready;

  // Only the odd-row/even-col phase folds in the column partial from the row above.
  assign cmp_a = (phase == 2'b10) ? lbuf[lb_idx] : hold;

  sm_max2 #(.DATA_W(DATA_W)) u_max (
    .a (cmp_a),
    .b (bus.in_data),
    .y (cmp_y)
  );

`ifdef MAXPOOL_RELU_EN
  assign pooled = cmp_y[DATA_W-1] ? '0 : cmp_y;
`else
  assign pooled = cmp_y;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (in_hs && col_last && row_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_hs) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      hold        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (in_hs) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        case (phase)
          2'b00:   hold  <= bus.in_data;
          2'b10:   hold  <= cmp_y;
          2'b11:   out_q <= pooled;
          default: ;
        endcase
      end
      if (in_hs && phase == 2'b11) out_valid_q <= 1'b1;
      else if (out_hs)             out_valid_q <= 1'b0;
    end
  end

  // Contents are don't-care between maps, so the line buffer carries no reset.
  always_ff @(posedge clk) begin
    if (in_hs && phase == 2'b01) lbuf[lb_idx] <= cmp_y;
  end
endmodule

// File: tb/tb_maxpool2x2_ctrl.sv
// tb/tb_maxpool2x2_ctrl.sv - scoreboard bench for the 2x2 max-pool controller on a 4x4 map.
module tb_maxpool2x2_ctrl;
  import maxpool_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst, start, busy, done;

  maxpool2x2_ctrl_if #(.DATA_W(DATA_W)) bus();

  maxpool2x2_ctrl #(.DATA_W(DATA_W), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  int      out_cnt = 0;
  logic    hs_prev = 1'b0;
  sample_t exp_q[$];
  sample_t map_a[16];
  sample_t map_b[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic sample_t neg(input int m);
    sample_t v;
    v = sample_t'(m);
    v[SIGN_BIT] = 1'b1;
    return v;
  endfunction

  function automatic sample_t pool_out(input sample_t v);
`ifdef MAXPOOL_RELU_EN
    return v[SIGN_BIT] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Monitor: an output handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h required none", bus.out_data);
      end else begin
        sample_t e;
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e);
      end
      out_cnt++;
    end
    hs_prev = !rst && bus.out_valid && bus.out_ready;
  end

  task automatic start_map();
    check("in_ready_idle", bus.in_ready, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("in_ready_after_start", bus.in_ready, 1);
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_map(input sample_t px[16], input int n, input bit lat_chk, output int cycles);
    logic hs;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = px[i];
      do begin
        @(negedge clk) hs = bus.in_ready;
        @(posedge clk); #1;
        cycles++;
        if (cycles > 500) begin
          $display("FAIL send_timeout: got %0d cycles required <= 500", cycles);
          $fatal(1);
        end
      end while (!hs);
      if (lat_chk && i == 4) check("out_valid_before_window", bus.out_valid, 0);
      if (lat_chk && i == 5) check("out_valid_latency", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n_exp);
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk); #1;
    end
    check("done_seen", done, 1);
    check("done_after_last_hs", hs_prev, 1);
    check("busy_with_done", busy, 0);
    check("out_count", out_cnt, n_exp);
    check("queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic push_a();
    exp_q.push_back(sample_t'(5));
    exp_q.push_back(sample_t'(7));
    exp_q.push_back(sample_t'(13));
    exp_q.push_back(sample_t'(15));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) map_a[i] = sample_t'(i);
    map_b = '{neg(3), neg(1), sample_t'(0), neg(0),
              neg(7), neg(2), neg(0), neg(0),
              neg(5), neg(5), neg(4), sample_t'(2),
              neg(9), neg(9), sample_t'(2), neg(0)};

    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ascending map, downstream always ready.
    out_cnt = 0; push_a();
    start_map();
    send_map(map_a, 16, 1'b1, cyc);
    check("throughput_cycles", cyc, 16);
    wait_done(4);

    // Negative, signed-zero and tie windows.
    out_cnt = 0;
    exp_q.push_back(pool_out(neg(1)));
    exp_q.push_back(pool_out(sample_t'(0)));
    exp_q.push_back(pool_out(neg(5)));
    exp_q.push_back(pool_out(sample_t'(2)));
    start_map();
    send_map(map_b, 16, 1'b0, cyc);
    wait_done(4);

    // Downstream stall for 6 cycles on the first result.
    out_cnt = 0; push_a();
    bus.out_ready = 1'b0;
    start_map();
    fork
      send_map(map_a, 16, 1'b0, cyc);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (bus.out_valid) break;
        end
        for (int k = 0; k < 6; k++) begin
          check("stall_in_ready", bus.in_ready, 0);
          check("stall_out_valid", bus.out_valid, 1);
          if (k < 5) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done(4);

    // Reset after 7 accepted inputs.
    out_cnt = 0;
    exp_q.push_back(sample_t'(5));
    start_map();
    send_map(map_a, 7, 1'b0, cyc);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_out_count", out_cnt, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_rst_busy", busy, 0);

    // Fresh map after reset.
    out_cnt = 0; exp_q.delete(); push_a();
    start_map();
    send_map(map_a, 16, 1'b0, cyc);
    wait_done(4);

    // start pulsed mid-map must be ignored.
    out_cnt = 0; push_a();
    start_map();
    fork
      send_map(map_a, 16, 1'b0, cyc);
      begin
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_run_start", busy, 1);
      end
    join
    wait_done(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maxpool2x2_ctrl.md
# maxpool2x2_ctrl

Streaming 2×2/stride-2 max-pool controller for the LeNet-5 pooling layers. Accepts one feature map in row-major order over a valid/ready stream, time-shares a single sign-magnitude max comparator across the window, keeps per-column partial maxima in a half-row line buffer, and emits one pooled value per 2×2 window on a valid/ready output stream. It sits between a convolution layer's output stream and the next layer's input buffer.

## Interface
- `DATA_W`, 18: sample width, sign-magnitude; bit `DATA_W-1` = sign (1 = negative), low bits = magnitude.
- `IMG_W`, 28: input map width in pixels; must be even and ≥ 2.
- `IMG_H`, 28: input map height in pixels; must be even and ≥ 2.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins one map. Ignored unless in IDLE.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: controller accepts the sample this cycle.
- `in_data` in DATA_W: input sample.
- `out_valid` out 1: pooled sample valid.
- `out_ready` in 1: downstream accepts the pooled sample.
- `out_data` out DATA_W: pooled sample.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse after the last pooled sample's handshake.

## Operation
- States: IDLE → (start) RUN → (last pixel accepted) DRAIN → (final output handshake) DONE → IDLE next cycle. DONE asserts `done` for exactly one cycle.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each input handshake (`in_valid && in_ready`). `col` wraps to 0 and increments `row` at IMG_W-1.
- Even row, even col: `hold <= in_data`.
- Even row, odd col: `lbuf[col/2] <= max(hold, in_data)`.
- Odd row, even col: `hold <= max(lbuf[col/2], in_data)`.
- Odd row, odd col: `out_data <= max(hold, in_data)` and set `out_valid`.
- max(a,b) is the sign-magnitude max:
  - Non-negative beats negative.
  - Both non-negative: larger magnitude wins, tie → b.
  - Both negative: smaller magnitude wins, tie → a.
  - +0 beats −0.
- Exactly one comparator instance. Its operand mux is selected by the (row parity, col parity) phase.
- `in_ready = (state==RUN) && !(out_valid && !out_ready)`. The single output register is never overwritten while unconsumed.
- `out_valid` clears on handshake unless a new result loads in the same cycle. Simultaneous load and handshake leaves `out_valid` = 1 with the new data.
- Line buffer contents are don't-care between maps. Every entry is written on an even row before it is read.
- `rst` at any point: state IDLE, counters 0, `out_valid`/`busy`/`done`/`in_ready` = 0, `out_data` = 0. Any in-flight map is discarded.

## Timing
- Reset values: all outputs 0.
- `in_ready` rises the cycle after `start` is sampled in IDLE.
- Latency: `out_valid` rises the cycle after the handshake of window pixel (odd row, odd col).
- Throughput: one input per cycle while `out_ready` is held high. Output rate is 1 per 2 cycles on odd rows and 0 on even rows.
- DRAIN holds until the output handshake of the last window (IMG_H/2 × IMG_W/2 outputs total). `done` pulses the following cycle; `busy` drops with `done`.
- `start` during RUN, DRAIN or DONE is ignored.

## Configuration
- `MAXPOOL_RELU_EN`:
  - Defined: fused ReLU. A negative pooled result (sign bit 1, including −0) is emitted as all-zeros.
  - Undefined: the pooled result is emitted unmodified.
- Latency and handshake behaviour are identical in both builds.

## Structure
- Package `maxpool_pkg`:
  - `DATA_W` default and `SIGN_BIT = DATA_W-1`.
  - State enum `{IDLE, RUN, DRAIN, DONE}`.
  - Sign-magnitude sample typedef.
- Sub-module `sm_max2`: purely combinational sign-magnitude two-input max with the tie rules above. Instantiated once in the controller.
- Line buffer: IMG_W/2 × DATA_W registers, inline in the controller.

## Test plan
- 4×4 map, input values 0..15 as positive magnitudes, `out_ready` = 1 → outputs 5, 7, 13, 15 in order; `done` one cycle after the 4th handshake.
- 2×2 map, inputs −3, −1, −7, −2 (sign set) → output −1. With `MAXPOOL_RELU_EN` defined → output 0.
- Tie and zero cases on 2×2 maps: inputs +0, −0, −0, −0 → output +0. Inputs −5, −5, −9, −9 → output −5 (sign 1, magnitude 5).
- 4×4 map with `out_ready` low for 6 cycles when the first result appears → `in_ready` = 0 while stalled; no output lost or duplicated; outputs match the first test.
- Assert `rst` mid-map after 7 accepted inputs → all outputs 0 next edge. Restart with `start` and a fresh 4×4 map → correct outputs 5, 7, 13, 15.
- `start` pulsed during RUN → ignored; output count stays IMG_H/2 × IMG_W/2 (196 for 28×28).
